// File: rtl/vc_writeback_buffer.sv
// rtl/vc_writeback_buffer.sv - write-back buffer between the victim cache and memory
//
// Accepts dirty victim lines from the victim cache controller, acknowledges
// them one cycle after capture and queues them in a small FIFO that drains
// to the memory write channel. A write to a tag already queued overwrites
// that entry's data in place, so the newest data is what reaches memory.
//
// Optional feature macro: WBB_SNOOP_EN (enables the L1-miss snoop lookup;
// when undefined snoop_hit/snoop_line are tied to 0 and snoop inputs are unused).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wb_req*         write-back request from the VC (held until wb_resp_valid)
//   wb_resp_valid   one-cycle accept pulse back to the VC
//   mem_wr_*        head-of-queue write channel toward memory (valid/ready)
//   snoop_*         combinational lookup of a tag in the buffer
//   wbb_full/empty  occupancy flags
//   err_rd_req      sticky flag: a read request arrived on the write-back port

module vc_writeback_buffer #(
  parameter int TAG_WIDTH  = 20,
  parameter int LINE_BYTES = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_req,
  input  logic                    wb_req_write,
  input  logic [TAG_WIDTH-1:0]    wb_req_tag,
  input  logic [LINE_BYTES*8-1:0] wb_req_wdata,
  output logic                    wb_resp_valid,
  output logic                    mem_wr_valid,
  input  logic                    mem_wr_ready,
  output logic [TAG_WIDTH-1:0]    mem_wr_tag,
  output logic [LINE_BYTES*8-1:0] mem_wr_data,
  input  logic                    snoop_valid,
  input  logic [TAG_WIDTH-1:0]    snoop_tag,
  output logic                    snoop_hit,
  output logic [LINE_BYTES*8-1:0] snoop_line,
  output logic                    wbb_full,
  output logic                    wbb_empty,
  output logic                    err_rd_req
);

  localparam int DW = LINE_BYTES * 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    I_IDLE    = 2'd0,
    I_ACK     = 2'd1,
    I_RELEASE = 2'd2
  } istate_t;

  istate_t r_state;
  istate_t w_state_nxt;

  logic [DEPTH-1:0]     r_valid;
  logic [TAG_WIDTH-1:0] r_tag  [DEPTH];
  logic [DW-1:0]        r_data [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_err;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_match_any;
  logic [PW-1:0] w_match_idx;
  logic          w_accept;
  logic          w_coalesce;
  logic          w_alloc;

  // Occupancy is judged on the count at the start of the cycle; a pop in
  // the same cycle only frees space for the following cycle.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && mem_wr_ready;

  // Coalesce lookup. The head being popped this cycle is excluded so its
  // data cannot be overwritten as it leaves; such a write allocates anew.
  always_comb begin
    w_match_any = 1'b0;
    w_match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_tag[i] == wb_req_tag) &&
          !(w_pop && (PW'(i) == r_rd_ptr))) begin
        w_match_any = 1'b1;
        w_match_idx = PW'(i);
      end
    end
  end

  assign w_accept   = (r_state == I_IDLE) && wb_req && wb_req_write &&
                      (w_match_any || !w_full);
  assign w_coalesce = w_accept && w_match_any;
  assign w_alloc    = w_accept && !w_match_any;

  // Entry storage, pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_data[i]  <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PW'(1);
      end
      if (w_coalesce) begin
        r_data[w_match_idx] <= wb_req_wdata;
      end
      // Allocation needs a non-full buffer, so the write slot can never be
      // the head slot being popped in the same cycle.
      if (w_alloc) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_tag[r_wr_ptr]   <= wb_req_tag;
        r_data[r_wr_ptr]  <= wb_req_wdata;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read requests are never valid on this port; flag and ignore them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (wb_req && !wb_req_write) begin
      r_err <= 1'b1;
    end
  end

  // Ingress FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= I_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ingress FSM next state and ack. I_RELEASE waits for the VC to drop its
  // request so a held request is never captured twice.
  always_comb begin
    w_state_nxt   = r_state;
    wb_resp_valid = 1'b0;
    case (r_state)
      I_IDLE: begin
        if (w_accept) begin
          w_state_nxt = I_ACK;
        end
      end
      I_ACK: begin
        wb_resp_valid = 1'b1;
        w_state_nxt   = I_RELEASE;
      end
      I_RELEASE: begin
        if (!wb_req) begin
          w_state_nxt = I_IDLE;
        end
      end
      default: begin
        w_state_nxt = I_IDLE;
      end
    endcase
  end

  assign mem_wr_valid = !w_empty;
  assign mem_wr_tag   = r_tag[r_rd_ptr];
  assign mem_wr_data  = r_data[r_rd_ptr];
  assign wbb_full     = w_full;
  assign wbb_empty    = w_empty;
  assign err_rd_req   = r_err;

`ifdef WBB_SNOOP_EN
  logic          w_snoop_any;
  logic [DW-1:0] w_snoop_line;

  // At most one entry can match because writes to a queued tag coalesce.
  // Reads the registered array, so a same-cycle coalesce returns old data.
  always_comb begin
    w_snoop_any  = 1'b0;
    w_snoop_line = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_tag[i] == snoop_tag)) begin
        w_snoop_any  = 1'b1;
        w_snoop_line = r_data[i];
      end
    end
  end

  assign snoop_hit  = snoop_valid && w_snoop_any;
  assign snoop_line = snoop_hit ? w_snoop_line : '0;
`else
  logic w_unused_snoop;

  assign w_unused_snoop = ^{snoop_valid, snoop_tag};
  assign snoop_hit      = 1'b0;
  assign snoop_line     = '0;
`endif

endmodule

// File: tb/tb_vc_writeback_buffer.sv
// tb/tb_vc_writeback_buffer.sv - self-checking bench for vc_writeback_buffer

module tb_vc_writeback_buffer;

  localparam int TW = 20;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_req = 1'b0;
  logic          wb_req_write = 1'b0;
  logic [TW-1:0] wb_req_tag = '0;
  logic [DW-1:0] wb_req_wdata = '0;
  logic          wb_resp_valid;
  logic          mem_wr_valid;
  logic          mem_wr_ready = 1'b0;
  logic [TW-1:0] mem_wr_tag;
  logic [DW-1:0] mem_wr_data;
  logic          snoop_valid = 1'b0;
  logic [TW-1:0] snoop_tag = '0;
  logic          snoop_hit;
  logic [DW-1:0] snoop_line;
  logic          wbb_full;
  logic          wbb_empty;
  logic          err_rd_req;

  vc_writeback_buffer #(.TAG_WIDTH(TW), .LINE_BYTES(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_req(wb_req), .wb_req_write(wb_req_write),
    .wb_req_tag(wb_req_tag), .wb_req_wdata(wb_req_wdata),
    .wb_resp_valid(wb_resp_valid),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_tag(mem_wr_tag), .mem_wr_data(mem_wr_data),
    .snoop_valid(snoop_valid), .snoop_tag(snoop_tag),
    .snoop_hit(snoop_hit), .snoop_line(snoop_line),
    .wbb_full(wbb_full), .wbb_empty(wbb_empty), .err_rd_req(err_rd_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } line_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    int            hold;
    int            exp_lat;
    logic          exp_mv;
  } vec_t;

  line_t sb_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  function automatic void check(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endfunction

  // Reference model update at the cycle the ack is observed: overwrite a
  // queued tag in place, otherwise append.
  function automatic void sb_write(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    bit found = 0;
    foreach (sb_q[i]) begin
      if (sb_q[i].tag == tag) begin
        sb_q[i].data = data;
        found = 1;
      end
    end
    if (!found) sb_q.push_back('{tag: tag, data: data});
  endfunction

  // Drain monitor: every beat accepted by memory must be the next expected line.
  always @(negedge clk) begin
    #2;
    if (rst_n && mem_wr_valid && mem_wr_ready) begin
      if (sb_q.size() == 0) begin
        fail_now("drain_unexpected");
      end else begin
        line_t e;
        e = sb_q.pop_front();
        check("drain_tag", {108'd0, mem_wr_tag}, {108'd0, e.tag});
        check("drain_data", mem_wr_data, e.data);
      end
    end
  end

  task automatic do_wb(input logic [TW-1:0] tag, input logic [DW-1:0] data,
                       input int hold, input bit set_ready,
                       output int lat, output logic mv);
    bit got = 0;
    @(posedge clk); #1;
    wb_req = 1'b1; wb_req_write = 1'b1; wb_req_tag = tag; wb_req_wdata = data;
    if (set_ready) mem_wr_ready = 1'b1;
    lat = 0;
    mv  = 1'b0;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      if (wb_resp_valid) got = 1;
    end
    if (!got) fail_now("ack_timeout");
    else begin
      mv = mem_wr_valid;
      sb_write(tag, data);
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    wb_req = 1'b0;
  endtask

  // Request against a full buffer: no ack while stalled, then memory ready
  // rises; the pop frees space only for the cycle after.
  task automatic wb_stalled(input logic [TW-1:0] tag, input logic [DW-1:0] data,
                            input int stall, output int lat);
    bit got = 0;
    @(posedge clk); #1;
    wb_req = 1'b1; wb_req_write = 1'b1; wb_req_tag = tag; wb_req_wdata = data;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_no_ack", {127'd0, wb_resp_valid}, 128'd0);
      check("stall_full", {127'd0, wbb_full}, 128'd1);
    end
    @(posedge clk); #1;
    mem_wr_ready = 1'b1;
    lat = 0;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      if (wb_resp_valid) got = 1;
    end
    if (!got) fail_now("stall_ack_timeout");
    else sb_write(tag, data);
    @(posedge clk); #1;
    wb_req = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    @(negedge clk);
    while (!wbb_empty && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!wbb_empty) fail_now(name);
    @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    mem_wr_ready = v;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   lat;
    logic mv;
    logic exp_hit;

    vecs[0] = '{tag: 20'h00ABC, data: {16{8'h11}}, hold: 0, exp_lat: 2, exp_mv: 1'b1};
    vecs[1] = '{tag: 20'h00000, data: 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                hold: 0, exp_lat: 2, exp_mv: 1'b1};
    vecs[2] = '{tag: 20'hFFFFF, data: {128{1'b1}}, hold: 1, exp_lat: 2, exp_mv: 1'b1};
    vecs[3] = '{tag: 20'h12345, data: {4{32'hDEAD_BEEF}}, hold: 3, exp_lat: 2, exp_mv: 1'b1};

    // Reset values
    #12;
    check("rst_resp", {127'd0, wb_resp_valid}, 128'd0);
    check("rst_mvalid", {127'd0, mem_wr_valid}, 128'd0);
    check("rst_empty", {127'd0, wbb_empty}, 128'd1);
    check("rst_full", {127'd0, wbb_full}, 128'd0);
    check("rst_err", {127'd0, err_rd_req}, 128'd0);
    check("rst_hit", {127'd0, snoop_hit}, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write-backs with memory always ready (last row holds wb_req)
    set_ready(1'b1);
    for (int v = 0; v < 4; v++) begin
      do_wb(vecs[v].tag, vecs[v].data, vecs[v].hold, 1'b0, lat, mv);
      check($sformatf("vec%0d_lat", v), 128'(lat), 128'(vecs[v].exp_lat));
      check($sformatf("vec%0d_mv_at_ack", v), {127'd0, mv}, {127'd0, vecs[v].exp_mv});
      wait_empty($sformatf("vec%0d_drain", v));
      check($sformatf("vec%0d_empty", v), {127'd0, wbb_empty}, 128'd1);
    end
    set_ready(1'b0);

    // Fill to full, stall a fifth request, then release memory
    for (int t = 1; t <= 4; t++) begin
      do_wb(TW'(t), {8{16'(t)}}, 0, 1'b0, lat, mv);
      check("fill_lat", 128'(lat), 128'd2);
    end
    @(negedge clk);
    check("full_flag", {127'd0, wbb_full}, 128'd1);
    check("full_not_empty", {127'd0, wbb_empty}, 128'd0);
    wb_stalled(20'd5, {8{16'h0005}}, 3, lat);
    check("full_accept_lat", 128'(lat), 128'd3);
    wait_empty("full_drain");
    set_ready(1'b0);

    // Coalesce: 7(A), 8, then 7(B); count must stay 2, so two more fill it
    do_wb(20'd7, {16{8'hAA}}, 0, 1'b0, lat, mv);
    do_wb(20'd8, {16{8'h88}}, 0, 1'b0, lat, mv);
    do_wb(20'd7, {16{8'hBB}}, 0, 1'b0, lat, mv);
    check("coal_lat", 128'(lat), 128'd2);
    @(negedge clk);
    check("coal_not_full", {127'd0, wbb_full}, 128'd0);
    do_wb(20'd9, {16{8'h99}}, 0, 1'b0, lat, mv);
    @(negedge clk);
    check("coal_3_not_full", {127'd0, wbb_full}, 128'd0);
    do_wb(20'd10, {16{8'h10}}, 0, 1'b0, lat, mv);
    @(negedge clk);
    check("coal_4_full", {127'd0, wbb_full}, 128'd1);
    set_ready(1'b1);
    wait_empty("coal_drain");
    set_ready(1'b0);

    // Write to the tag of the head being popped allocates a new entry
    do_wb(20'h00020, {16{8'h01}}, 0, 1'b0, lat, mv);
    do_wb(20'h00020, {16{8'h02}}, 0, 1'b1, lat, mv);
    check("head_pop_lat", 128'(lat), 128'd2);
    wait_empty("head_pop_drain");
    set_ready(1'b0);

    // Read request: never acked, sticky error
    @(posedge clk); #1;
    wb_req = 1'b1; wb_req_write = 1'b0; wb_req_tag = 20'h00555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rd_no_ack", {127'd0, wb_resp_valid}, 128'd0);
    end
    @(posedge clk); #1;
    wb_req = 1'b0;
    @(negedge clk);
    check("rd_err", {127'd0, err_rd_req}, 128'd1);
    check("rd_empty", {127'd0, wbb_empty}, 128'd1);

    // Snoop
`ifdef WBB_SNOOP_EN
    exp_hit = 1'b1;
`else
    exp_hit = 1'b0;
`endif
    do_wb(20'h00F00, {8{16'hF00D}}, 0, 1'b0, lat, mv);
    @(posedge clk); #1;
    snoop_valid = 1'b1; snoop_tag = 20'h00F00;
    @(negedge clk);
    check("snoop_hit", {127'd0, snoop_hit}, {127'd0, exp_hit});
    check("snoop_line", snoop_line, exp_hit ? {8{16'hF00D}} : 128'd0);
    @(posedge clk); #1;
    snoop_tag = 20'h00F01;
    @(negedge clk);
    check("snoop_miss", {127'd0, snoop_hit}, 128'd0);
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    set_ready(1'b1);
    wait_empty("snoop_drain");
    set_ready(1'b0);

    // Reset with three entries queued
    for (int t = 0; t < 3; t++) do_wb(TW'(20'h31 + t), {4{32'(t)}}, 0, 1'b0, lat, mv);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", {127'd0, wbb_empty}, 128'd1);
    check("mid_rst_mvalid", {127'd0, mem_wr_valid}, 128'd0);
    check("mid_rst_resp", {127'd0, wb_resp_valid}, 128'd0);
    check("mid_rst_err", {127'd0, err_rd_req}, 128'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Buffer works again after reset
    set_ready(1'b1);
    do_wb(20'h00040, {16{8'h40}}, 0, 1'b0, lat, mv);
    check("post_rst_lat", 128'(lat), 128'd2);
    wait_empty("post_rst_drain");
    repeat (3) @(negedge clk);
    check("sb_all_drained", 128'(sb_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
